vga_scan_gen: RTL and testbench

Upstream timing stage of the VGA output path. It divides the system clock down to a pixel tick and runs the horizontal and vertical scan counters for 640x480@60. It drives the `x`/`y` pixel coordinates consumed by the image display stages, such as the title overlay, which address their image ROMs with them. It also generates `hsync`, `vsync` and `active`, delayed by a configurable number of pixel ticks so they line up with the one-cycle-late ROM colour data.

---
 rtl/vga_scan_if.sv | 19 +
 rtl/vga_scan_gen.sv | 112 +++++++++++
 tb/tb_vga_scan_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// Output bundle of the VGA scan generator: pixel strobe, raw coordinates and delayed sync/active.
// Free-running stream with no backpressure; consumers sample on pixel_tick and gate with active.
interface vga_scan_if;
    logic       pixel_tick;
    logic [9:0] x;
    logic [8:0] y;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       frame_start;

    modport master (
        output pixel_tick, x, y, hsync, vsync, active, frame_start
    );

    modport slave (
        input pixel_tick, x, y, hsync, vsync, active, frame_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
// 640x480@60 scan timing: clock divider, h/v counters and sync/active decodes delayed
// by SYNC_DELAY pixel ticks to line up with one-cycle-late image ROM data.
module vga_scan_gen #(
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 1,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic       clk,
    input  logic       resetn,
    vga_scan_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [2:0]            div;
    logic [9:0]            h_cnt;
    logic [9:0]            v_cnt;
    logic                  tick;
    logic                  hs_raw;
    logic                  vs_raw;
    logic                  act_raw;
    logic [SYNC_DELAY-1:0] hs_pipe;
    logic [SYNC_DELAY-1:0] vs_pipe;
    logic [SYNC_DELAY-1:0] act_pipe;
    logic                  frame_start_q;

    // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so the tick is permanently high.
    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign act_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // Pulse marks the tick that wraps the scan to (0,0); reset alone never raises it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            act_pipe <= '0;
        end else if (tick) begin
            for (int i = SYNC_DELAY - 1; i > 0; i--) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            act_pipe[0] <= act_raw;
        end
    end

    assign vga.pixel_tick  = tick;
    assign vga.x           = h_cnt;
    assign vga.y           = v_cnt[8:0];
    assign vga.hsync       = hs_pipe[SYNC_DELAY-1];
    assign vga.vsync       = vs_pipe[SYNC_DELAY-1];
    assign vga.active      = act_pipe[SYNC_DELAY-1];
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: three instances with different divider/delay/timing settings,
// each compared every clock against an arithmetic model driven by the count of clocks since reset.
module tb_vga_scan_gen;
    // Instance 0: divider 2, delay 1, shrunken timing so many frames fit in the run.
    localparam int A_DIV = 2, A_SD = 1;
    localparam int A_HV = 16, A_HFP = 4, A_HS = 6, A_HBP = 6;
    localparam int A_VV = 12, A_VFP = 3, A_VS = 2, A_VBP = 4;
    // Instance 1: divider 1, delay 3, small timing.
    localparam int B_DIV = 1, B_SD = 3;
    localparam int B_HV = 10, B_HFP = 2, B_HS = 3, B_HBP = 3;
    localparam int B_VV = 8, B_VFP = 2, B_VS = 2, B_VBP = 2;
    // Instance 2: divider 3, delay 4, full 640x480 timing (a few lines only).
    localparam int C_DIV = 3, C_SD = 4;
    localparam int C_HV = 640, C_HFP = 16, C_HS = 96, C_HBP = 48;
    localparam int C_VV = 480, C_VFP = 10, C_VS = 2, C_VBP = 33;

    localparam int OW = 24;

    logic clk = 1'b0;
    logic resetn;

    vga_scan_if if_a ();
    vga_scan_if if_b ();
    vga_scan_if if_c ();

    vga_scan_gen #(
        .CLK_DIV(A_DIV), .SYNC_DELAY(A_SD),
        .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP)
    ) u_a (.clk(clk), .resetn(resetn), .vga(if_a.master));

    vga_scan_gen #(
        .CLK_DIV(B_DIV), .SYNC_DELAY(B_SD),
        .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
    ) u_b (.clk(clk), .resetn(resetn), .vga(if_b.master));

    vga_scan_gen #(
        .CLK_DIV(C_DIV), .SYNC_DELAY(C_SD),
        .H_VISIBLE(C_HV), .H_FP(C_HFP), .H_SYNC(C_HS), .H_BP(C_HBP),
        .V_VISIBLE(C_VV), .V_FP(C_VFP), .V_SYNC(C_VS), .V_BP(C_VBP)
    ) u_c (.clk(clk), .resetn(resetn), .vga(if_c.master));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // k = rising edges seen with resetn high since the last reset.
    // Output packing: {pixel_tick, x[9:0], y[8:0], hsync, vsync, active, frame_start}
    function automatic logic [OW-1:0] model(input int c, input int k);
        int d, sd, hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
        int ht, vt, n, h, v, m, hm, vm;
        logic pt, hs, vs, act, fs;
        logic [9:0] xv;
        logic [9:0] yv;
        case (c)
            0: begin d = A_DIV; sd = A_SD; hv = A_HV; hfp = A_HFP; hsw = A_HS; hbp = A_HBP;
                     vv = A_VV; vfp = A_VFP; vsw = A_VS; vbp = A_VBP; end
            1: begin d = B_DIV; sd = B_SD; hv = B_HV; hfp = B_HFP; hsw = B_HS; hbp = B_HBP;
                     vv = B_VV; vfp = B_VFP; vsw = B_VS; vbp = B_VBP; end
            default: begin d = C_DIV; sd = C_SD; hv = C_HV; hfp = C_HFP; hsw = C_HS; hbp = C_HBP;
                     vv = C_VV; vfp = C_VFP; vsw = C_VS; vbp = C_VBP; end
        endcase
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        n  = k / d;
        pt = ((k % d) == d - 1);
        h  = n % ht;
        v  = (n / ht) % vt;
        if (n >= sd) begin
            m   = n - sd;
            hm  = m % ht;
            vm  = (m / ht) % vt;
            hs  = !((hm >= hv + hfp) && (hm < hv + hfp + hsw));
            vs  = !((vm >= vv + vfp) && (vm < vv + vfp + vsw));
            act = (hm < hv) && (vm < vv);
        end else begin
            hs  = 1'b1;
            vs  = 1'b1;
            act = 1'b0;
        end
        fs = (k > 0) && ((k % d) == 0) && ((n % (ht * vt)) == 0);
        xv = 10'(h);
        yv = 10'(v);
        return {pt, xv, yv[8:0], hs, vs, act, fs};
    endfunction

    function automatic logic [3*OW-1:0] model_all(input int k);
        return {model(2, k), model(1, k), model(0, k)};
    endfunction

    logic [OW-1:0] obs_a, obs_b, obs_c;
    assign obs_a = {if_a.pixel_tick, if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.active, if_a.frame_start};
    assign obs_b = {if_b.pixel_tick, if_b.x, if_b.y, if_b.hsync, if_b.vsync, if_b.active, if_b.frame_start};
    assign obs_c = {if_c.pixel_tick, if_c.x, if_c.y, if_c.hsync, if_c.vsync, if_c.active, if_c.frame_start};

    // ---------------- scoreboard ----------------
    logic [3*OW-1:0] exp_q[$];
    int k = 0;
    int checks = 0;
    int errors = 0;

    task automatic check_vec(input string name, input int c, input logic [OW-1:0] got,
                             input logic [OW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d k=%0d got %h exp %h (pt,x,y,hs,vs,act,fs)",
                     name, c, k, got, want);
        end
    endtask

    // Stimulus side: each clock edge defines the next expected output set.
    always @(posedge clk) begin
        if (resetn === 1'b1) k++;
        exp_q.push_back(model_all(k));
    end

    // Asynchronous reset invalidates anything pending.
    always @(negedge resetn) begin
        k = 0;
        exp_q.delete();
    end

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        logic [3*OW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec("scan", 0, obs_a, e[OW-1:0]);
            check_vec("scan", 1, obs_b, e[2*OW-1:OW]);
            check_vec("scan", 2, obs_c, e[3*OW-1:2*OW]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_vec("rst_async", 0, obs_a, model(0, 0));
        check_vec("rst_async", 1, obs_b, model(1, 0));
        check_vec("rst_async", 2, obs_c, model(2, 0));
        run_cycles(hold);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        run_cycles(5);
        @(negedge clk);
        resetn = 1'b1;
        // Several small frames for instances 0/1, a few full lines for instance 2.
        run_cycles(9000);
        for (int r = 0; r < 3; r++) begin
            async_reset($urandom_range(1, 4));
            run_cycles($urandom_range(2000, 5000));
        end
        @(negedge clk);
        #1;
        if (checks < 1000) begin
            errors++;
            $display("FAIL check_budget got %0d checks exp at least 1000", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
